// File: rtl/port_out_buffer.sv
// Purpose: per-port egress FIFO between the switch input FSM and the port consumer, gated by a RUN/DRAIN/IDLE FSM.
// Latency: a write is visible on port_out/port_ready one cycle later (first-word-fall-through, no bypass when empty).
// Backpressure: port_busy is register-decoded (not in RUN, or occupancy >= BUSY_THR); writes at full without a pop are dropped and flagged.
module port_out_buffer #(
    parameter int W_WIDTH  = 8,
    parameter int DEPTH    = 8,
    parameter int BUSY_THR = DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_en,
    input  logic               wr_en,
    input  logic [W_WIDTH-1:0] data_in,
    output logic               port_busy,
    input  logic               port_read,
    output logic               port_ready,
    output logic [W_WIDTH-1:0] port_out,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_BUSY  = (AW+1)'(BUSY_THR);
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [W_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [AW:0]        w_count_nxt;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_run;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_run   = (r_state == S_RUN);

    // Pops are legal in any state; a push at full is allowed only when a pop frees the slot this cycle.
    assign w_pop  = port_read & ~w_empty;
    assign w_push = wr_en & w_run & (~w_full | w_pop);
    assign w_drop = wr_en & w_run & w_full & ~w_pop;

    // Occupancy for next cycle; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Control FSM: DRAIN empties the queue after sw_en drops, re-enabling takes priority over going idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (sw_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!sw_en) w_state_nxt = w_empty ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (sw_en)                   w_state_nxt = S_RUN;
                else if (w_count_nxt == '0)  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    // Head data is forced to zero while empty so stale or uninitialised entries never leak out.
    assign port_out   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign port_ready = ~w_empty;
    assign port_busy  = ~w_run | (r_count >= C_BUSY);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_port_out_buffer.sv
module tb_port_out_buffer;

    logic       clk;
    logic       rst_n;
    logic       sw_en;
    logic       wr_en;
    logic [7:0] data_in;
    logic       port_busy;
    logic       port_read;
    logic       port_ready;
    logic [7:0] port_out;
    logic       overflow;

    int         n_chk;
    int         n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    port_out_buffer #(
        .W_WIDTH (8),
        .DEPTH   (8),
        .BUSY_THR(7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_en     (sw_en),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .port_busy (port_busy),
        .port_read (port_read),
        .port_ready(port_ready),
        .port_out  (port_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake that will complete at the next rising edge is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && port_read && port_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h, expected no data", port_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", {24'h0, port_out}, {24'h0, mon_exp});
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en     = w;
        data_in   = d;
        port_read = r;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        port_read = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        exp_q.push_back(d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0);
    endtask

    // Mid-cycle reset pulse; outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, "_ready"}, port_ready, 0);
        chk({tag, "_busy"}, port_busy, 1);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_out"}, port_out, 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        sw_en     = 1'b0;
        wr_en     = 1'b0;
        data_in   = 8'h00;
        port_read = 1'b0;
        #2;
        chk("rst_ready", port_ready, 0);
        chk("rst_busy", port_busy, 1);
        chk("rst_out", port_out, 0);
        chk("rst_ovf", overflow, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write / read-out ordering and one-cycle visibility.
        sw_en = 1'b1;
        idle();
        chk("run_busy", port_busy, 0);
        wr(8'h11);
        chk("t1_ready", port_ready, 1);
        chk("t1_head", port_out, 8'h11);
        wr(8'h22);
        wr(8'h33);
        rd();
        rd();
        rd();
        chk("t1_empty", port_ready, 0);

        // Busy threshold, full acceptance, drop at full and sticky overflow.
        for (int i = 0; i < 7; i++) begin
            wr(8'hA0 + 8'(i));
            if (i == 5) chk("t2_busy6", port_busy, 0);
        end
        chk("t2_busy7", port_busy, 1);
        wr(8'hA7);
        chk("t2_ovf8", overflow, 0);
        step(1'b1, 8'hFF, 1'b0);
        chk("t2_ovf9", overflow, 1);
        idle();
        chk("t2_ovf_sticky", overflow, 1);
        for (int i = 0; i < 8; i++) rd();
        chk("t2_empty", port_ready, 0);
        chk("t2_ovf_kept", overflow, 1);
        mid_reset("t2rst");
        idle();

        // Push and pop together at full.
        for (int i = 0; i < 8; i++) wr(8'hB0 + 8'(i));
        chk("t3_busy", port_busy, 1);
        exp_q.push_back(8'hC0);
        step(1'b1, 8'hC0, 1'b1);
        chk("t3_ovf", overflow, 0);
        chk("t3_busy_full", port_busy, 1);
        for (int i = 0; i < 8; i++) rd();
        chk("t3_empty", port_ready, 0);

        // Streaming through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'(i));
            step(1'b1, 8'(i), 1'b1);
        end
        rd();
        chk("t4_empty", port_ready, 0);

        // Drain on sw_en drop, writes ignored, re-enable keeps data.
        wr(8'hD0);
        wr(8'hD1);
        wr(8'hD2);
        sw_en = 1'b0;
        idle();
        chk("t5_drain_busy", port_busy, 1);
        step(1'b1, 8'hEE, 1'b0);
        chk("t5_drain_ovf", overflow, 0);
        rd();
        sw_en = 1'b1;
        idle();
        chk("t5_rerun_busy", port_busy, 0);
        chk("t5_kept_ready", port_ready, 1);
        rd();
        rd();
        chk("t5_empty", port_ready, 0);
        wr(8'hE0);
        wr(8'hE1);
        wr(8'hE2);
        sw_en = 1'b0;
        idle();
        rd();
        rd();
        rd();
        chk("t5_idle_ready", port_ready, 0);
        chk("t5_idle_busy", port_busy, 1);
        step(1'b1, 8'h77, 1'b0);
        chk("t5_idle_wr", port_ready, 0);

        // Asynchronous reset with data queued.
        sw_en = 1'b1;
        idle();
        wr(8'hF0);
        wr(8'hF1);
        wr(8'hF2);
        wr(8'hF3);
        chk("t6_pre_ready", port_ready, 1);
        mid_reset("t6rst");
        idle();
        wr(8'h5A);
        rd();
        chk("t6_post_empty", port_ready, 0);

        chk("sb_leftover", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
